div_unit: RTL and testbench



---
 rtl/div_unit_pkg.sv | 16 +
 rtl/div_step.sv | 28 ++
 rtl/div_unit.sv | 141 ++++++++++++++
 tb/tb_div_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared constants for the iterative divider: operation encodings and FSM states.
package div_unit_pkg;

  // Operation encodings; bit 1 selects remainder, bit 0 selects unsigned.
  localparam logic [1:0] DIV_OP_DIV  = 2'd0;
  localparam logic [1:0] DIV_OP_DIVU = 2'd1;
  localparam logic [1:0] DIV_OP_REM  = 2'd2;
  localparam logic [1:0] DIV_OP_REMU = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift the next dividend bit into the
// partial remainder, then subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   div_ext;

  // Shift/compare/subtract for a single quotient bit.
  always_comb begin
    shifted  = {rem[WIDTH-1:0], quo[WIDTH-1]};
    div_ext  = {1'b0, divisor};
    quo_next = {quo[WIDTH-2:0], 1'b0};
    rem_next = shifted;
    if (shifted >= div_ext) begin
      rem_next    = shifted - div_ext;
      quo_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_unit.sv
// Sequential 32-bit DIV/DIVU/REM/REMU unit, one quotient bit per cycle.
// Division runs on magnitudes; signs are reapplied when the result register
// is loaded. Divide-by-zero and signed overflow skip the iterations.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_kill,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_busy
);

  localparam logic [WIDTH-1:0] MIN_INT   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [5:0]       LAST_ITER = 6'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic             accept, finish;
  logic             signed_op, is_rem, a_neg, b_neg, div_zero, ovf;
  logic [WIDTH-1:0] a_mag, b_mag, spec_res, final_res;

  logic [WIDTH:0]   rem_q, rem_next;
  logic [WIDTH-1:0] quo_q, quo_next, divisor_q, spec_res_q, result_q;
  logic             rem_sel_q, qneg_q, rneg_q, special_q;
  logic [5:0]       cnt_q;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (divisor_q),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Operand decode at accept: magnitudes, signs and special-case result.
  always_comb begin
    signed_op = (i_op == DIV_OP_DIV) || (i_op == DIV_OP_REM);
    is_rem    = (i_op == DIV_OP_REM) || (i_op == DIV_OP_REMU);
    a_neg     = signed_op && i_a[WIDTH-1];
    b_neg     = signed_op && i_b[WIDTH-1];
    a_mag     = cond_neg(i_a, a_neg);
    b_mag     = cond_neg(i_b, b_neg);
    div_zero  = (i_b == '0);
    ovf       = signed_op && (i_a == MIN_INT) && (i_b == '1);
    spec_res  = '0;
    if (div_zero)
      spec_res = is_rem ? i_a : '1;
    else if (ovf)
      spec_res = is_rem ? '0 : MIN_INT;
  end

  // Result selection with sign restoration for the final iteration.
  always_comb begin
    final_res = rem_sel_q ? cond_neg(rem_next[WIDTH-1:0], rneg_q)
                          : cond_neg(quo_next, qneg_q);
    if (special_q)
      final_res = spec_res_q;
  end

  // Next-state and handshake outputs; kill overrides every transition.
  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    o_valid = 1'b0;
    o_busy  = 1'b0;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        accept  = i_valid && !i_kill;
        if (accept) state_d = CALC;
      end
      CALC: begin
        o_busy = 1'b1;
        finish = special_q || (cnt_q == LAST_ITER);
        if (finish) state_d = DONE;
      end
      DONE: begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (i_kill) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Datapath: latch operands at accept, iterate in CALC, load result at finish.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rem_q      <= '0;
      quo_q      <= '0;
      divisor_q  <= '0;
      spec_res_q <= '0;
      result_q   <= '0;
      rem_sel_q  <= 1'b0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      special_q  <= 1'b0;
      cnt_q      <= '0;
    end else if (accept) begin
      rem_q      <= '0;
      quo_q      <= a_mag;
      divisor_q  <= b_mag;
      spec_res_q <= spec_res;
      rem_sel_q  <= is_rem;
      qneg_q     <= a_neg ^ b_neg;
      rneg_q     <= a_neg;
      special_q  <= div_zero || ovf;
      cnt_q      <= '0;
    end else if (state_q == CALC) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
      cnt_q <= cnt_q + 6'd1;
      if (finish) result_q <= final_res;
    end
  end

  assign o_result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results are queued at request time
// and compared when the unit presents a result that the consumer accepts.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk, rst_n;
  logic        i_valid, i_kill, i_ready;
  logic [1:0]  i_op;
  logic [31:0] i_a, i_b;
  logic        o_ready, o_valid, o_busy;
  logic [31:0] o_result;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];

  div_unit #(.WIDTH(32)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_kill   (i_kill),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_busy   (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    case (op)
      DIV_OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      DIV_OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      DIV_OP_REM:  return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default:     return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Result monitor: pops the scoreboard on every accepted result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_ready && o_valid) check("ready_valid_exclusive", 32'd1, 32'd0);
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", o_result, 32'hFFFF_FFFF ^ o_result);
        else                   check("result", o_result, exp_q.pop_front());
      end
    end
  end

  // Issue one request from just after a rising edge, check latency,
  // optional backpressure, and the return to idle.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input int bp);
    int          cycles;
    logic [31:0] held;
    i_valid = 1'b1; i_op = op; i_a = a; i_b = b;
    i_ready = (bp == 0);
    exp_q.push_back(exp);
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_a = $urandom; i_b = $urandom; i_op = 2'($urandom_range(0, 3));
    cycles = 0;
    while (!o_valid && cycles < 80) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("latency", 32'(cycles), 32'(lat));
    if (!o_valid) begin
      void'(exp_q.pop_back());
      i_ready = 1'b1;
      return;
    end
    if (bp > 0) begin
      held = o_result;
      i_valid = 1'b1; i_op = DIV_OP_DIVU; i_a = 32'd99; i_b = 32'd3;
      for (int k = 0; k < bp; k++) begin
        @(posedge clk); #1;
        check("bp_result_hold", o_result, held);
        check("bp_ready_low", {31'd0, o_ready}, 32'd0);
        check("bp_valid_high", {31'd0, o_valid}, 32'd1);
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("post_handshake_ready", {31'd0, o_ready}, 32'd1);
    check("post_handshake_valid", {31'd0, o_valid}, 32'd0);
  endtask

  task automatic start_untracked(input logic [31:0] a, input logic [31:0] b, input int iters);
    i_valid = 1'b1; i_op = DIV_OP_DIVU; i_a = a; i_b = b;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (iters) @(posedge clk);
    #1;
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int seen;
    seen = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (o_valid) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    rst_n = 1'b0; i_valid = 1'b0; i_kill = 1'b0; i_ready = 1'b1;
    i_op = 2'd0; i_a = '0; i_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready",  {31'd0, o_ready}, 32'd1);
    check("reset_valid",  {31'd0, o_valid}, 32'd0);
    check("reset_busy",   {31'd0, o_busy},  32'd0);
    check("reset_result", o_result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(DIV_OP_DIV,  32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32, 0);
    do_op(DIV_OP_REM,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32, 0);
    do_op(DIV_OP_REMU, 32'hFFFF_FFF9,  32'd2,         32'd1,         32, 0);
    do_op(DIV_OP_DIVU, 32'h1234_5678,  32'd0,         32'hFFFF_FFFF, 1,  0);
    do_op(DIV_OP_REMU, 32'h1234_5678,  32'd0,         32'h1234_5678, 1,  0);
    do_op(DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  0);
    do_op(DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  0);
    do_op(DIV_OP_DIV,  32'h8000_0000,  32'd1,         32'h8000_0000, 32, 0);
    do_op(DIV_OP_DIVU, 32'd1000,       32'd7,         32'd142,       32, 5);

    // Kill beats a simultaneous request in IDLE.
    i_valid = 1'b1; i_kill = 1'b1; i_op = DIV_OP_DIVU; i_a = 32'd5; i_b = 32'd1;
    @(posedge clk); #1;
    i_valid = 1'b0; i_kill = 1'b0;
    check("kill_vs_accept_ready", {31'd0, o_ready}, 32'd1);
    check("kill_vs_accept_busy",  {31'd0, o_busy},  32'd0);
    expect_quiet("kill_vs_accept_no_valid", 40);

    // Kill in the middle of the iterations.
    start_untracked(32'd1000, 32'd3, 10);
    i_kill = 1'b1;
    @(posedge clk); #1;
    i_kill = 1'b0;
    check("kill_ready", {31'd0, o_ready}, 32'd1);
    check("kill_busy",  {31'd0, o_busy},  32'd0);
    expect_quiet("kill_no_valid", 40);
    do_op(DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 32, 0);

    // Asynchronous reset in the middle of the iterations.
    start_untracked(32'hDEAD_BEEF, 32'd5, 20);
    rst_n = 1'b0;
    #1;
    check("async_rst_ready",  {31'd0, o_ready}, 32'd1);
    check("async_rst_valid",  {31'd0, o_valid}, 32'd0);
    check("async_rst_result", o_result, 32'd0);
    check("async_rst_busy",   {31'd0, o_busy},  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_quiet("async_rst_no_valid", 40);
    do_op(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32, 0);

    // Randomised mix including small and negative divisors.
    for (int n = 0; n < 10; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case (n % 3)
        0:       b = 32'($urandom_range(0, 4));
        1:       b = -32'($urandom_range(1, 9));
        default: b = $urandom >> $urandom_range(0, 28);
      endcase
      do_op(op, a, b, model(op, a, b), is_special(op, a, b) ? 1 : 32, n % 2);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
